// File: rtl/aes128_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : aes128_round_ctrl
// Description : Iterative AES-128 encryption controller. Runs one cipher round
//               per clock over a single shared SubBytes/ShiftRows/MixColumns/
//               AddRoundKey datapath, with an on-the-fly key schedule and
//               valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module aes128_round_ctrl #(
    parameter int NUM_ROUNDS = 10,
    parameter int HOLD_KEY   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy,
    output logic [3:0]   round_idx
);

    // AES S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Last round that still includes MixColumns.
    localparam logic [3:0] c_LAST_MID = 4'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } fsm_t;

    fsm_t         r_fsm;
    logic [127:0] r_state;
    logic [127:0] r_rk;
    logic [3:0]   r_round_idx;
    logic         r_in_ready;
    logic         r_out_valid;
    logic         r_busy;

    logic [127:0] w_sub_bytes;
    logic [127:0] w_shifted;
    logic [127:0] w_mixed;
    logic [127:0] w_next_rk;
    logic [127:0] w_round_out;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub_word;
    logic [31:0]  w_w0;
    logic [31:0]  w_w1;
    logic [31:0]  w_w2;
    logic [31:0]  w_w3;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        // Entry x sits at bit offset 8*(255-x), and 255-x is simply ~x.
        return c_SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Column-major byte order: byte 4c+r is row r of column c, byte 0 on top.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] w);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] v;
        case (i)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    // The single SubBytes stage: sixteen S-boxes on the state register.
    for (genvar i = 0; i < 16; i++) begin : g_sub_bytes
        assign w_sub_bytes[8*i +: 8] = sbox(r_state[8*i +: 8]);
    end

    // SubWord(RotWord(word3)) for the key schedule: four more S-boxes.
    assign w_rot = {r_rk[23:0], r_rk[31:24]};
    for (genvar i = 0; i < 4; i++) begin : g_sub_word
        assign w_sub_word[8*i +: 8] = sbox(w_rot[8*i +: 8]);
    end

    assign w_w0      = r_rk[127:96] ^ w_sub_word ^ {rcon(r_round_idx), 24'h0};
    assign w_w1      = r_rk[95:64]  ^ w_w0;
    assign w_w2      = r_rk[63:32]  ^ w_w1;
    assign w_w3      = r_rk[31:0]   ^ w_w2;
    assign w_next_rk = {w_w0, w_w1, w_w2, w_w3};

    assign w_shifted = shift_rows(w_sub_bytes);
    assign w_mixed   = {mix_col(w_shifted[127:96]), mix_col(w_shifted[95:64]),
                        mix_col(w_shifted[63:32]),  mix_col(w_shifted[31:0])};

    // The final round skips MixColumns; every round adds the freshly derived key.
    assign w_round_out = ((r_fsm == ST_FINAL) ? w_shifted : w_mixed) ^ w_next_rk;

    // Control FSM with registered handshake/status outputs and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= ST_IDLE;
            r_state     <= '0;
            r_rk        <= '0;
            r_round_idx <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_fsm)
                ST_IDLE: begin
                    // Without key holding the register simply tracks in_key while idle.
                    if (HOLD_KEY == 0) begin
                        r_rk <= in_key;
                    end
                    if (in_valid && r_in_ready) begin
                        r_state     <= in_state ^ in_key;
                        r_rk        <= in_key;
                        r_round_idx <= 4'd1;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                        r_fsm       <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    r_state     <= w_round_out;
                    r_rk        <= w_next_rk;
                    r_round_idx <= r_round_idx + 4'd1;
                    if (r_round_idx == c_LAST_MID) begin
                        r_fsm <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    r_state     <= w_round_out;
                    r_rk        <= w_next_rk;
                    r_out_valid <= 1'b1;
                    r_fsm       <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_round_idx <= '0;
                        r_fsm       <= ST_IDLE;
                    end
                end
                default: begin
                    r_fsm <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_state = r_state;
    assign busy      = r_busy;
    assign round_idx = r_round_idx;

endmodule
`default_nettype wire

// File: tb/tb_aes128_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes128_round_ctrl
// Description : Directed self-checking bench for aes128_round_ctrl using
//               FIPS-197 vectors and an expected-ciphertext queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes128_round_ctrl;

    localparam logic [127:0] c_C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] c_C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] c_C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] c_B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] c_B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] c_B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] c_B_R1   = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] c_Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;
    logic [3:0]   round_idx;

    int           n_checks    = 0;
    int           n_errors    = 0;
    int           n_accepts   = 0;
    int           last_accept = 0;
    int           edge_n      = 0;
    logic [127:0] cur_exp;
    logic [127:0] sb_q[$];

    aes128_round_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy),
        .round_idx (round_idx)
    );

    always #5 clk = ~clk;

    // Rising-edge counter used to measure latency and issue interval.
    always @(posedge clk) edge_n <= edge_n + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Called just before a rising edge: records handshakes that edge will complete.
    task automatic observe();
        if (in_valid && in_ready) begin
            sb_q.push_back(cur_exp);
            n_accepts++;
            last_accept = edge_n + 1;
        end
        if (out_valid && out_ready) begin
            chki("output_expected", int'(sb_q.size() > 0), 1);
            if (sb_q.size() > 0) begin
                chk("ciphertext", out_state, sb_q.pop_front());
            end
        end
    endtask

    task automatic adv();
        observe();
        @(negedge clk);
    endtask

    task automatic run_vec(input string tag, input logic [127:0] k,
                           input logic [127:0] p, input logic [127:0] e);
        int n0;
        int guard;
        n0        = n_accepts;
        in_key    = k;
        in_state  = p;
        cur_exp   = e;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        adv();
        in_valid = 1'b0;
        chki({tag, "_accepted"}, n_accepts - n0, 1);
        guard = 0;
        while (!out_valid && guard < 40) begin
            adv();
            guard++;
        end
        chki({tag, "_latency"}, edge_n + 1 - last_accept, 11);
        adv();
        chki({tag, "_in_ready_after"}, int'(in_ready), 1);
    endtask

    initial begin
        int guard;
        int acc1;
        int n0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;
        in_key    = '0;
        cur_exp   = '0;
        @(negedge clk);
        @(negedge clk);
        chki("rst_in_ready", int'(in_ready), 1);
        chki("rst_out_valid", int'(out_valid), 0);
        chki("rst_busy", int'(busy), 0);
        chki("rst_round_idx", int'(round_idx), 0);
        chk("rst_out_state", out_state, '0);
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 C.1 vector
        run_vec("c1", c_C1_KEY, c_C1_PT, c_C1_CT);

        // Appendix B vector with round tracking, then 20 cycles of backpressure
        out_ready = 1'b0;
        in_key    = c_B_KEY;
        in_state  = c_B_PT;
        cur_exp   = c_B_CT;
        in_valid  = 1'b1;
        adv();
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chki("b_round_idx", int'(round_idx), k);
            chki("b_busy", int'(busy), 1);
            if (k == 2) chk("b_round1_state", dut.r_state, c_B_R1);
            adv();
        end
        chki("b_out_valid", int'(out_valid), 1);
        chki("b_latency", edge_n + 1 - last_accept, 11);
        for (int i = 0; i < 20; i++) begin
            chk("bp_out_state", out_state, c_B_CT);
            chki("bp_out_valid", int'(out_valid), 1);
            chki("bp_in_ready", int'(in_ready), 0);
            chki("bp_busy", int'(busy), 1);
            in_valid = (i % 2 == 1);
            adv();
        end
        in_valid  = 1'b0;
        chki("bp_round_idx_done", int'(round_idx), 10);
        out_ready = 1'b1;
        adv();
        chki("bp_in_ready_after", int'(in_ready), 1);
        chki("bp_out_valid_after", int'(out_valid), 0);
        chki("bp_busy_after", int'(busy), 0);
        chki("bp_round_idx_after", int'(round_idx), 0);

        // Back-to-back issue with in_valid toggling during rounds
        n0        = n_accepts;
        in_key    = c_C1_KEY;
        in_state  = c_C1_PT;
        cur_exp   = c_C1_CT;
        in_valid  = 1'b1;
        adv();
        acc1     = last_accept;
        in_key   = '0;
        in_state = '0;
        cur_exp  = c_Z_CT;
        for (int i = 0; i < 30 && n_accepts < n0 + 2; i++) begin
            in_valid = !(i == 2 || i == 3 || i == 6);
            chki("b2b_in_ready", int'(in_ready), (i >= 11) ? 1 : 0);
            adv();
        end
        chki("b2b_interval", last_accept - acc1, 12);
        in_valid = 1'b0;
        guard = 0;
        while (sb_q.size() != 0 && guard < 40) begin
            adv();
            guard++;
        end
        chki("b2b_drained", sb_q.size(), 0);

        // Reset in the middle of round 5
        in_key   = c_C1_KEY;
        in_state = c_C1_PT;
        cur_exp  = c_C1_CT;
        in_valid = 1'b1;
        adv();
        in_valid = 1'b0;
        guard = 0;
        while (round_idx != 4'd5 && guard < 20) begin
            adv();
            guard++;
        end
        chki("mr_reached_round5", int'(round_idx), 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        chki("mr_in_ready", int'(in_ready), 1);
        chki("mr_out_valid", int'(out_valid), 0);
        chki("mr_round_idx", int'(round_idx), 0);
        chki("mr_busy", int'(busy), 0);
        chk("mr_out_state", out_state, '0);
        run_vec("mr_c1", c_C1_KEY, c_C1_PT, c_C1_CT);

        // All-zero key and plaintext
        run_vec("zero", '0, '0, c_Z_CT);

        chki("sb_empty_end", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/aes128_round_ctrl.md
Name: aes128_round_ctrl

Overview:
Iterative AES-128 encryption engine controller. It sequences one round per clock over a shared round datapath: the existing shiftrows block, plus internal SubBytes, MixColumns and AddRoundKey. It owns the 128-bit state register, the on-the-fly key schedule and round counter, and the valid/ready handshakes to the upstream and downstream stages. It sits between the block-input FIFO and the ciphertext output stage of the crypto core.

Parameters:
- NUM_ROUNDS, 10, number of cipher rounds; fixed at 10 for AES-128, other values unsupported.
- HOLD_KEY, 1, if 1 the input key is latched at accept; if 0, in_key must stay stable until out_valid.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  plaintext and key are valid
- in_ready  output  1  controller can accept a block
- in_state  input  128  plaintext; [127:120] is byte s0,0, column-major as in shiftrows
- in_key  input  128  cipher key, same byte order
- out_valid  output  1  ciphertext valid
- out_ready  input  1  downstream accepts ciphertext
- out_state  output  128  ciphertext
- busy  output  1  high from accept until the ciphertext handshake completes
- round_idx  output  4  current round number, 0 in IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset (rst=1 at a clock edge):
  - FSM goes to IDLE; state and key registers cleared to 0.
  - in_ready=1, out_valid=0, busy=0, round_idx=0, out_state=0.
  - Reset during an operation discards the block; no partial output is ever presented.
- FSM states: IDLE, ROUND, FINAL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: state <= in_state ^ in_key; rk <= in_key; round_idx <= 1; go to ROUND.
- ROUND (round_idx 1..9), one round per cycle:
  - rk <= next round key using rcon[round_idx]; rcon = 01,02,04,08,10,20,40,80,1b,36.
  - state <= MixColumns(shiftrows(SubBytes(state))) ^ next_rk.
  - round_idx increments; after round 9 go to FINAL.
- FINAL (round_idx 10):
  - state <= shiftrows(SubBytes(state)) ^ next_rk, with no MixColumns.
  - Go to DONE.
- DONE:
  - out_valid=1 and out_state = state register.
  - Held stable while out_ready=0, for any number of cycles.
  - On out_valid&&out_ready: go to IDLE, out_valid=0 next cycle.
- Latency: accept at edge T gives out_valid=1 from edge T+11. Minimum issue interval is 12 cycles, because in_ready rises the cycle after the output handshake.
- in_ready=0 in all states except IDLE; in_valid outside IDLE is ignored and not buffered.
- busy=1 in ROUND, FINAL and DONE.
- round_idx: 0 in IDLE, 1..10 during processing, 10 in DONE.
- Key schedule:
  - next_rk word0 = rk word0 ^ SubWord(RotWord(rk word3)) ^ {rcon,24'h0}.
  - word i = word i-1 ^ rk word i, for i = 1..3.
  - Words are 32-bit, word0 = [127:96].
- in_state/in_key are sampled only at the accept edge (HOLD_KEY=1).
- Datapath blocks are shared: exactly one SubBytes/shiftrows/MixColumns instance plus four S-boxes for SubWord. All are combinational between registers.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Test Plan:
- Reset, then FIPS-197 C.1 vector:
  - in_key=000102030405060708090a0b0c0d0e0f, in_state=00112233445566778899aabbccddeeff.
  - Expect out_state=69c4e0d86a7b0430d8cdb78070b4c55a, out_valid exactly 11 cycles after accept.
- FIPS-197 Appendix B vector:
  - in_key=2b7e151628aed2a6abf7158809cf4f3c, in_state=3243f6a8885a308d313198a2e0370734.
  - Expect 3925841d02dc09fbdc118597196a0b32.
  - Check round_idx steps 1..10; the round-1 state register = a49c7ff2689f352b6b5bea43026a5049.
- Backpressure:
  - Hold out_ready=0 for 20 cycles after out_valid.
  - out_state stays stable, in_ready stays 0, busy stays 1.
  - Raise out_ready: handshake completes, in_ready=1 the next cycle.
- Back-to-back issue:
  - Keep in_valid=1 with a new vector queued and out_ready=1.
  - Second accept occurs exactly 12 cycles after the first; both ciphertexts are correct.
  - in_valid toggled mid-round has no effect.
- Mid-operation reset:
  - Pulse rst at round_idx=5.
  - Next cycle: in_ready=1, out_valid=0, round_idx=0, out_state=0.
  - A fresh C.1 vector then yields the correct ciphertext.
- Edge case: all-zero key and plaintext produce 66e94bd4ef8a2c3b884cfa59ca342b2e.
